// File: rtl/resistor_capacitor_high_pass_filter.sv
// First-order RC high-pass filter: y[n] = ALPHA*(y[n-1] + x[n] - x[n-1]) / 2^16,
// computed with a 16-cycle shift-and-add multiplier per accepted sample strobe.
module resistor_capacitor_high_pass_filter #(
  parameter int SAMPLE_RATE  = 48000,
  parameter int R            = 47000,
  parameter int C_35_SHIFTED = 1615
) (
  input  logic               clk,
  input  logic               I_RST,
  input  logic               audio_clk_en,
  input  logic signed [15:0] in,
  output logic signed [15:0] out,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  // Filter coefficient: ALPHA = RC/(RC+DT) in Q16, with DT = 2^32/fs and RC in the same scale.
  localparam longint DT          = 64'sd4294967296 / longint'(SAMPLE_RATE);
  localparam longint RC          = (longint'(R) * longint'(C_35_SHIFTED)) >>> 3;
  localparam longint ALPHA_RAW   = (RC <<< 16) / (RC + DT);
  localparam longint ALPHA_CLAMP = (ALPHA_RAW > 64'sd65535) ? 64'sd65535 : ALPHA_RAW;
  localparam logic [15:0] ALPHA  = ALPHA_CLAMP[15:0];

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e             state_q, state_d;
  logic signed [15:0] x_cur_q, x_cur_d;
  logic signed [15:0] x_prev_q, x_prev_d;
  logic signed [15:0] y_prev_q, y_prev_d;
  logic signed [17:0] s_q, s_d;
  logic signed [33:0] acc_q, acc_d;
  logic        [3:0]  cnt_q, cnt_d;
  logic signed [15:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;

  logic signed [33:0] s_ext;
  logic signed [33:0] acc_shr;
  logic signed [15:0] sat;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    x_cur_d     = x_cur_q;
    x_prev_d    = x_prev_q;
    y_prev_d    = y_prev_q;
    s_d         = s_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;

    s_ext   = {{16{s_q[17]}}, s_q};
    // Arithmetic shift floors toward minus infinity, then clamp to the 16-bit range.
    acc_shr = acc_q >>> 16;
    if (acc_shr > 34'sd32767)       sat = 16'sh7fff;
    else if (acc_shr < -34'sd32768) sat = 16'sh8000;
    else                            sat = acc_shr[15:0];

    unique case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          x_cur_d = in;
          s_d     = {{2{y_prev_q[15]}}, y_prev_q} + {{2{in[15]}}, in}
                  - {{2{x_prev_q[15]}}, x_prev_q};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (ALPHA[cnt_q]) acc_d = acc_q + (s_ext <<< cnt_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        out_d       = sat;
        y_prev_d    = sat;
        x_prev_d    = x_cur_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A strobe while a sample is in flight is dropped but remembered until reset.
    if (state_q != IDLE && audio_clk_en) overrun_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge I_RST) begin
    if (I_RST) begin
      state_q     <= IDLE;
      x_cur_q     <= '0;
      x_prev_q    <= '0;
      y_prev_q    <= '0;
      s_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_cur_q     <= x_cur_d;
      x_prev_q    <= x_prev_d;
      y_prev_q    <= y_prev_d;
      s_q         <= s_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_resistor_capacitor_high_pass_filter.sv
// Scoreboard bench: two filter instances (default ALPHA and ALPHA=65535) driven in lockstep,
// expectations from an arithmetic reference model, checked by an independent monitor.
module tb_resistor_capacitor_high_pass_filter;

  localparam int ALPHA_A = 64923;
  localparam int ALPHA_B = 65535;
  localparam int LAT     = 17;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en  = 1'b0;
  logic signed [15:0] din = '0;

  logic signed [15:0] out_a, out_b;
  logic               valid_a, valid_b, busy_a, busy_b, ovr_a, ovr_b;

  resistor_capacitor_high_pass_filter dut_a (
    .clk(clk), .I_RST(rst), .audio_clk_en(en), .in(din),
    .out(out_a), .out_valid(valid_a), .busy(busy_a), .overrun(ovr_a)
  );

  resistor_capacitor_high_pass_filter #(.R(100000000)) dut_b (
    .clk(clk), .I_RST(rst), .audio_clk_en(en), .in(din),
    .out(out_b), .out_valid(valid_b), .busy(busy_b), .overrun(ovr_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int a; int b; int c; } exp_t;
  exp_t sb[$];

  int passed = 0;
  int total  = 0;

  // Model state
  int  m_ya, m_yb, m_x;
  int  last_acc;
  bit  have_acc;
  bit  ovr_exp;
  int  last_a, last_b;
  int  seen_a, seen_b;
  bit  decay_mode;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: floor(alpha*(y_prev + x - x_prev) / 65536), clamped to signed 16 bits.
  function automatic int hp(input int alpha, input int yp, input int x, input int xp);
    longint s, p, q;
    s = longint'(yp) + longint'(x) - longint'(xp);
    p = s * longint'(alpha);
    q = p / 65536;
    if (p < 0 && (p % 65536) != 0) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sb.delete();
    m_ya = 0; m_yb = 0; m_x = 0;
    have_acc = 1'b0; ovr_exp = 1'b0;
    last_a = 0; last_b = 0;
    #1;
    check("rst_out",     int'(out_a), 0);
    check("rst_valid",   int'(valid_a), 0);
    check("rst_busy",    int'(busy_a), 0);
    check("rst_overrun", int'(ovr_a), 0);
    check("rst_out_b",   int'(out_b), 0);
    tick();
    tick();
    rst = 1'b0;
    last_acc = cyc - 100;
  endtask

  // Strobe x so that it is accepted at least `gap` edges after the previous accepted strobe.
  task automatic send(input int x, input int gap);
    exp_t e;
    while (cyc < last_acc + gap - 1) tick();
    din = 16'(x);
    en  = 1'b1;
    tick();
    en  = 1'b0;
    din = 16'($urandom);
    e.a = hp(ALPHA_A, m_ya, x, m_x);
    e.b = hp(ALPHA_B, m_yb, x, m_x);
    e.c = cyc;
    m_ya = e.a; m_yb = e.b; m_x = x;
    sb.push_back(e);
    last_acc = cyc;
    have_acc = 1'b1;
  endtask

  // Dropped strobe: lands k+1 edges after the accepting edge, while busy.
  task automatic extra_strobe(input int k);
    repeat (k) tick();
    din = 16'($urandom);
    en  = 1'b1;
    tick();
    en  = 1'b0;
    ovr_exp = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) return;
      tick();
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      bit   busy_exp;
      busy_exp = have_acc && ((cyc - last_acc) <= 16);
      check("busy_a", int'(busy_a), int'(busy_exp));
      check("busy_b", int'(busy_b), int'(busy_exp));
      check("overrun_a", int'(ovr_a), int'(ovr_exp));
      check("overrun_b", int'(ovr_b), int'(ovr_exp));
      if (valid_a) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_a", int'(out_a), e.a);
          check("out_b", int'(out_b), e.b);
          check("valid_b", int'(valid_b), 1);
          check("latency", cyc - e.c, LAT);
          if (decay_mode) check("decay", int'(iabs(int'(out_a)) <= iabs(last_a)), 1);
          last_a = e.a;
          last_b = e.b;
          seen_a = int'(out_a);
          seen_b = int'(out_b);
        end
      end else begin
        check("hold_a", int'(out_a), last_a);
        check("hold_b", int'(out_b), last_b);
        check("valid_b_low", int'(valid_b), 0);
      end
    end
  end

  initial begin
    int x, k;
    decay_mode = 1'b0;
    tick();
    apply_reset();

    // Step response and second sample
    send(10000, 18);
    drain();
    check("step1", seen_a, 9906);
    send(10000, 18);
    drain();
    check("step2", seen_a, 9813);

    // Floor rounding on negative input
    apply_reset();
    send(-10000, 18);
    drain();
    check("floor_neg", seen_a, -9907);

    // Saturation on the ALPHA=65535 instance
    apply_reset();
    send(32767, 18);
    drain();
    check("sat_pos", seen_b, 32766);
    send(-32768, 18);
    drain();
    check("sat_neg", seen_b, -32768);

    // Dropped strobe 5 cycles after acceptance
    apply_reset();
    send(10000, 18);
    extra_strobe(4);
    drain();
    check("overrun_result", seen_a, 9906);
    check("overrun_sticky", int'(ovr_a), 1);
    repeat (30) tick();
    check("overrun_still", int'(ovr_a), 1);

    // Reset 8 cycles into the multiply
    apply_reset();
    send(10000, 18);
    repeat (7) tick();
    apply_reset();
    check("midrst_overrun", int'(ovr_a), 0);
    repeat (25) tick();
    check("midrst_out", int'(out_a), 0);
    send(10000, 18);
    drain();
    check("midrst_after", seen_a, 9906);

    // Back-to-back throughput at the minimum period
    apply_reset();
    send(1000, 18);
    send(0, 18);
    decay_mode = 1'b1;
    for (int i = 1; i < 100; i++) send(0, 18);
    drain();
    decay_mode = 1'b0;
    check("thru_overrun", int'(ovr_a), 0);

    // Randomized samples, gaps and dropped strobes
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 65535)) - 32768;
      else                           x = int'($urandom_range(0, 8000)) - 4000;
      send(x, int'($urandom_range(18, 24)));
      if ($urandom_range(0, 5) == 0) begin
        k = int'($urandom_range(1, 15));
        extra_strobe(k);
      end
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
